rhythm_window_analyzer: RTL
===========================

Name: rhythm_window_analyzer

Overview:
Parametrised rolling-window rhythm classifier. It consumes per-beat live flags (brady/tachy/irreg) and keeps a WIN_DEPTH-deep history of beat classes with incrementally maintained per-class counts. On each trigger it selects the dominant class and computes an exact confidence score, floor(dom_count*255/fill), using a multi-cycle divider FSM. It sits between the per-beat rhythm classifiers and the display/report logic.

Parameters:
WIN_DEPTH, 8, window length in beats; power of 2, range 4..64
MIN_FORCE, 4, minimum fill level that allows a forced analysis; range 1..WIN_DEPTH
CNT_W, $clog2(WIN_DEPTH)+1, derived count width; not overridden

Ports:
clk  in  1  clock
rst  in  1  reset
beat_valid  in  1  one-cycle strobe: a new beat's flags are valid
live_brady  in  1  beat flag
live_tachy  in  1  beat flag
live_irreg  in  1  beat flag
force_anlz  in  1  level; its rising edge requests analysis
win_clear  in  1  flush the window
final_diag  out  2  00 normal, 01 brady, 10 tachy, 11 irregular
confidence  out  8  0..255
diag_valid  out  1  one-cycle pulse when final_diag/confidence update
busy  out  1  high while the divider FSM is not IDLE
force_reject  out  1  one-cycle pulse when a force request is refused
fill_level  out  CNT_W  beats currently held, 0..WIN_DEPTH
class_counts  out  4*CNT_W  {irreg,tachy,brady,normal} counts, normal in the LSBs

Behaviour:
- Reset: rst is synchronous, active-high; clk is the clock. All outputs go to 0. Window, pointer, counts, force edge register and pending flag are cleared. FSM goes to IDLE. Reset mid-divide aborts with no diag_valid.
- Beat class codes, in priority order: irreg -> 11, else brady -> 01, else tachy -> 10, else 00.
- Beat push on beat_valid:
  - The code is written at wr_ptr; the pointer wraps modulo WIN_DEPTH.
  - If fill < WIN_DEPTH: fill++ and the new class count is incremented.
  - If fill == WIN_DEPTH: the overwritten slot's class is decremented and the new class incremented in the same cycle. If both are the same class, that count is unchanged.
  - Invariant: the four counts sum to fill at all times.
- class_counts and fill_level reflect the push on the cycle after the beat_valid edge.
- Triggers, evaluated on the same edge:
  - Auto: beat_valid while the window is already full, or the push that fills it.
  - Force: force_anlz rising edge (registered edge detect) with post-push fill >= MIN_FORCE.
  - A force edge with fill < MIN_FORCE gives a force_reject pulse on the next cycle and no trigger.
  - A beat and a force on the same edge form one trigger, and the counts include that beat.
- FSM IDLE -> DIV -> DONE -> IDLE:
  - Trigger edge E0. At E1, IDLE -> DIV: snapshot the post-E0 counts and fill, select the dominant class, load numerator dom*255 (CNT_W+8 bits) and divisor fill.
  - Dominant class is the maximum count. Ties resolve irreg > tachy > brady > normal.
  - DIV: restoring division, one quotient bit per cycle, 8 cycles (E2..E9).
  - At E10 (DONE): final_diag and confidence are written and diag_valid = 1 for exactly one cycle. Latency is 10 cycles from the trigger edge.
  - DONE -> IDLE, or -> DIV directly if a trigger is pending.
- dom == fill gives exactly 255; the divisor is never 0.
- A trigger while busy sets pending; multiple triggers coalesce to one. A pending analysis snapshots the counts current at its own DIV-entry edge.
- busy = (state != IDLE).
- Beats continue to update the window while busy; the snapshot isolates the division.
- win_clear:
  - Zeroes fill, counts and pointer, clears pending, and sends the FSM to IDLE with no diag_valid.
  - final_diag and confidence hold their last values.
  - A beat on the same edge is dropped (clear wins); a force on the same edge is rejected.
- Outputs hold between diag_valid pulses.

Test Plan:
1. WIN_DEPTH=8. Reset, then 8 normal beats 4 cycles apart -> no diag before the 8th beat. diag_valid 10 cycles after the 8th beat with diag=00, conf=255, fill_level=8.
2. Full window of 8 tachy, then 3 brady beats spaced 12 cycles -> counts tachy=5, brady=3. Final result diag=10, conf=159; three diag_valid pulses.
3. Window of 4 irreg + 4 normal -> tie gives diag=11, conf=127.
4. After reset, 3 beats then force -> force_reject pulse, no diag_valid. Add 2 more beats (3 brady, 2 normal), then force -> diag=01, conf=153 after 10 cycles.
5. Full window, beats on 5 consecutive cycles -> exactly 2 diag_valid pulses. The second reflects the final counts and follows the first by 9 cycles; busy stays high between them.
6. win_clear, and separately rst, asserted at cycle 5 of DIV -> no diag_valid, fill_level=0, busy=0. For win_clear, final_diag and confidence keep their prior values.

Source files
------------

// File: rtl/rhythm_window_analyzer.sv
// Rolling-window rhythm classifier: per-class beat counts, dominant class and confidence floor(dom*255/fill).
// Result appears 10 cycles after a trigger; triggers arriving while busy coalesce into one pending analysis.
module rhythm_window_analyzer #(
    parameter int WIN_DEPTH = 8,
    parameter int MIN_FORCE = 4,
    parameter int CNT_W     = $clog2(WIN_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 beat_valid,
    input  logic                 live_brady,
    input  logic                 live_tachy,
    input  logic                 live_irreg,
    input  logic                 force_anlz,
    input  logic                 win_clear,
    output logic [1:0]           final_diag,
    output logic [7:0]           confidence,
    output logic                 diag_valid,
    output logic                 busy,
    output logic                 force_reject,
    output logic [CNT_W-1:0]     fill_level,
    output logic [4*CNT_W-1:0]   class_counts
);

    localparam int PTR_W = $clog2(WIN_DEPTH);
    localparam int NUM_W = CNT_W + 8;

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t             state_q, state_d;
    logic [1:0]         win_q [WIN_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   fill_q, fill_d;
    logic [CNT_W-1:0]   cnt_q [4];
    logic [CNT_W-1:0]   cnt_d [4];
    logic               force_prev_q;
    logic               pending_q, pending_d;
    logic               force_reject_q, force_reject_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]   div_q, div_d;
    logic [7:0]         num_lo_q, num_lo_d;
    logic [7:0]         quo_q, quo_d;
    logic [2:0]         bit_q, bit_d;
    logic [1:0]         dom_cls_q, dom_cls_d;
    logic [1:0]         final_q, final_d;
    logic [7:0]         conf_q, conf_d;
    logic               diag_valid_q, diag_valid_d;

    logic [1:0]         new_cls;
    logic [1:0]         old_cls;
    logic               push;
    logic               full;
    logic               force_edge;
    logic               force_ok;
    logic               auto_trig;
    logic               trig;
    logic               load;
    logic [1:0]         dom_sel;
    logic [CNT_W-1:0]   dom_cnt;
    logic [NUM_W-1:0]   num;
    logic [CNT_W:0]     rem_sh;
    logic               ge;
    logic [CNT_W-1:0]   rem_next;

    assign new_cls    = live_irreg ? 2'b11 : live_brady ? 2'b01 : live_tachy ? 2'b10 : 2'b00;
    assign old_cls    = win_q[wr_ptr_q];
    assign push       = beat_valid & ~win_clear;
    assign full       = (fill_q == CNT_W'(WIN_DEPTH));
    assign force_edge = force_anlz & ~force_prev_q;

    // Window bookkeeping: a full-window push retires the overwritten class in the same cycle.
    always_comb begin
        fill_d   = fill_q;
        wr_ptr_d = wr_ptr_q;
        for (int k = 0; k < 4; k++) cnt_d[k] = cnt_q[k];
        if (win_clear) begin
            fill_d   = '0;
            wr_ptr_d = '0;
            for (int k = 0; k < 4; k++) cnt_d[k] = '0;
        end else if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (!full) fill_d = fill_q + CNT_W'(1);
            for (int k = 0; k < 4; k++) begin
                if (2'(k) == new_cls && !(full && old_cls == new_cls))
                    cnt_d[k] = cnt_q[k] + CNT_W'(1);
                else if (full && 2'(k) == old_cls && old_cls != new_cls)
                    cnt_d[k] = cnt_q[k] - CNT_W'(1);
            end
        end
    end

    assign auto_trig      = push & (fill_d == CNT_W'(WIN_DEPTH));
    assign force_ok       = force_edge & ~win_clear & (fill_d >= CNT_W'(MIN_FORCE));
    assign force_reject_d = force_edge & ~force_ok;
    assign trig           = auto_trig | force_ok;

    // Later classes win ties, giving irreg > tachy > brady > normal.
    always_comb begin
        dom_sel = 2'b00;
        dom_cnt = cnt_q[0];
        for (int k = 1; k < 4; k++) begin
            if (cnt_q[k] >= dom_cnt) begin
                dom_sel = 2'(k);
                dom_cnt = cnt_q[k];
            end
        end
    end

    assign num      = ({8'b0, dom_cnt} << 8) - {8'b0, dom_cnt};
    assign rem_sh   = {rem_q, num_lo_q[7]};
    assign ge       = (rem_sh >= {1'b0, div_q});
    assign rem_next = ge ? CNT_W'(rem_sh - {1'b0, div_q}) : rem_sh[CNT_W-1:0];

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        rem_d        = rem_q;
        div_d        = div_q;
        num_lo_d     = num_lo_q;
        quo_d        = quo_q;
        bit_d        = bit_q;
        dom_cls_d    = dom_cls_q;
        final_d      = final_q;
        conf_d       = conf_q;
        diag_valid_d = 1'b0;
        load         = 1'b0;
        case (state_q)
            IDLE: begin
                if (pending_q) load = 1'b1;
            end
            DIV: begin
                rem_d    = rem_next;
                num_lo_d = {num_lo_q[6:0], 1'b0};
                quo_d    = {quo_q[6:0], ge};
                bit_d    = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = DONE;
            end
            DONE: begin
                final_d      = dom_cls_q;
                conf_d       = quo_q;
                diag_valid_d = 1'b1;
                state_d      = IDLE;
                if (pending_q) load = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // The top bits of dom*255 are already below fill, so 8 steps yield the full quotient.
        if (load) begin
            state_d   = DIV;
            pending_d = 1'b0;
            dom_cls_d = dom_sel;
            div_d     = fill_q;
            rem_d     = num[NUM_W-1:8];
            num_lo_d  = num[7:0];
            quo_d     = '0;
            bit_d     = '0;
        end
        if (trig) pending_d = 1'b1;
        if (win_clear) begin
            state_d      = IDLE;
            pending_d    = 1'b0;
            diag_valid_d = 1'b0;
            final_d      = final_q;
            conf_d       = conf_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            wr_ptr_q       <= '0;
            fill_q         <= '0;
            for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
            for (int k = 0; k < WIN_DEPTH; k++) win_q[k] <= 2'b00;
            force_prev_q   <= 1'b0;
            pending_q      <= 1'b0;
            force_reject_q <= 1'b0;
            rem_q          <= '0;
            div_q          <= '0;
            num_lo_q       <= '0;
            quo_q          <= '0;
            bit_q          <= '0;
            dom_cls_q      <= '0;
            final_q        <= '0;
            conf_q         <= '0;
            diag_valid_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            fill_q         <= fill_d;
            for (int k = 0; k < 4; k++) cnt_q[k] <= cnt_d[k];
            if (push) win_q[wr_ptr_q] <= new_cls;
            force_prev_q   <= force_anlz;
            pending_q      <= pending_d;
            force_reject_q <= force_reject_d;
            rem_q          <= rem_d;
            div_q          <= div_d;
            num_lo_q       <= num_lo_d;
            quo_q          <= quo_d;
            bit_q          <= bit_d;
            dom_cls_q      <= dom_cls_d;
            final_q        <= final_d;
            conf_q         <= conf_d;
            diag_valid_q   <= diag_valid_d;
        end
    end

    assign final_diag   = final_q;
    assign confidence   = conf_q;
    assign diag_valid   = diag_valid_q;
    assign busy         = (state_q != IDLE);
    assign force_reject = force_reject_q;
    assign fill_level   = fill_q;
    assign class_counts = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};

endmodule
